// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: default widths, opcode field, halt opcode, FSM states.
// HALT state is present only when IF_HALT_EN is defined.
package if_fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
`ifdef IF_HALT_EN
        ,
        HALT = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, presents instr/pc to ID (IF_HALT_EN adds halt-opcode stop).
// Latency: ack in the first REQ cycle gives if_valid the next cycle; peak rate one instruction per 2 cycles.
// Backpressure: instr_out/pc_out held in HOLD until id_ready; no new request is issued while holding.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef IF_HALT_EN
    ,
    parameter logic [3:0]       HALT_OPCODE = HALT_OPCODE_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               halted
);

    fetch_state_t       state_q;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               squash_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_out_q;
    logic               fetch_ok;

    assign fetch_ok = (state_q == REQ) && imem_ack && !squash_q && !redirect_valid;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (fetch_ok) state_nxt = HOLD;
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                end else if (id_ready) begin
`ifdef IF_HALT_EN
                    if (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE) state_nxt = HALT;
                    else                                         state_nxt = REQ;
`else
                    state_nxt = REQ;
`endif
                end
            end
`ifdef IF_HALT_EN
            HALT: begin
                if (redirect_valid) state_nxt = REQ;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            squash_q   <= 1'b0;
            instr_q    <= '0;
            pc_out_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (redirect_valid)  pc_q <= redirect_addr;
            else if (fetch_ok)   pc_q <= pc_q + ADDR_W'(1);
            if (fetch_ok) begin
                instr_q  <= imem_rdata;
                pc_out_q <= pc_q;
            end
            // The in-flight request keeps its address; only the first redirect snapshots it.
            if (state_q == REQ) begin
                if (imem_ack) begin
                    squash_q <= 1'b0;
                end else if (redirect_valid) begin
                    squash_q <= 1'b1;
                    if (!squash_q) req_addr_q <= pc_q;
                end
            end
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = squash_q ? req_addr_q : pc_q;
    assign if_valid  = (state_q == HOLD);
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
`ifdef IF_HALT_EN
    assign halted    = (state_q == HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction model of the expected fetch stream plus directed scenarios.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, if_valid, id_ready, redirect_valid, halted;
    logic [7:0]  imem_addr, pc_out, redirect_addr;
    logic [15:0] imem_rdata, instr_out;
    logic        req2, valid2, halted2;
    logic [7:0]  addr2, pc2;
    logic [15:0] instr2;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .id_ready(id_ready), .instr_out(instr_out), .pc_out(pc_out),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halted(halted)
    );

    // Second copy starting at FE shares every input; only its address stream is inspected.
    if_fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(valid2), .id_ready(id_ready), .instr_out(instr2), .pc_out(pc2),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halted(halted2)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem [256];
    int          ack_delay = 0;
    int          wcnt = 0;

    logic [7:0]  req_log[$];
    logic [7:0]  req2_log[$];
    logic [7:0]  xpc_log[$];
    logic [15:0] xin_log[$];
    bit          vld_log[$];
    bit          reqtr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        req_log.delete(); req2_log.delete(); xpc_log.delete();
        xin_log.delete(); vld_log.delete(); reqtr_log.delete();
    endtask

    // Memory: answers a request after ack_delay waiting cycles, data from the array.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk); #2;
            if (!imem_req || !reset) begin
                imem_ack = 1'b0; imem_rdata = 16'hDEAD; wcnt = 0;
            end else if (wcnt >= ack_delay) begin
                imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wcnt = 0;
            end else begin
                imem_ack = 1'b0; imem_rdata = 16'hDEAD; wcnt++;
            end
        end
    end

    // Model: transfers must deliver consecutive addresses from the last reset/redirect target.
    logic [7:0]  npc = 8'h00;
    logic [7:0]  addr_prev = 8'h00;
    logic [7:0]  hold_pc = 8'h00;
    logic [15:0] hold_instr = 16'h0;
    bit          pend_prev = 0, pend2_prev = 0, hold_prev = 0;

    initial begin
        forever begin
            @(negedge clk); #1;
            vld_log.push_back(if_valid);
            reqtr_log.push_back(imem_req);
            if (!reset) begin
                npc = 8'h00; pend_prev = 0; pend2_prev = 0; hold_prev = 0;
            end else begin
                if (imem_req && !pend_prev) req_log.push_back(imem_addr);
                if (imem_req && pend_prev)  chk("addr_stable", 32'(imem_addr), 32'(addr_prev));
                if (req2 && !pend2_prev)    req2_log.push_back(addr2);
                if (if_valid) begin
                    chk("instr_vs_mem", 32'(instr_out), 32'(mem[pc_out]));
                    chk("no_req_in_hold", 32'(imem_req), 32'd0);
                    if (hold_prev) begin
                        chk("hold_pc", 32'(pc_out), 32'(hold_pc));
                        chk("hold_instr", 32'(instr_out), 32'(hold_instr));
                    end
                end
`ifdef IF_HALT_EN
                if (halted) chk("no_req_in_halt", 32'(imem_req), 32'd0);
`else
                chk("halted_tied", 32'(halted), 32'd0);
`endif
                if (redirect_valid) begin
                    npc = redirect_addr;
                end else if (if_valid && id_ready) begin
                    chk("xfer_pc", 32'(pc_out), 32'(npc));
                    npc = npc + 8'd1;
                    xpc_log.push_back(pc_out);
                    xin_log.push_back(instr_out);
                end
                hold_prev  = if_valid && !id_ready && !redirect_valid;
                hold_pc    = pc_out;
                hold_instr = instr_out;
                pend_prev  = imem_req && !imem_ack;
                addr_prev  = imem_addr;
                pend2_prev = req2 && !imem_ack;
            end
        end
    end

    task automatic wait_ack();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #2;
            found = imem_req && imem_ack;
        end
        if (!found) chk("timeout_ack", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #2;
            found = if_valid;
        end
        if (!found) chk("timeout_valid", 32'd0, 32'd1);
    endtask

    task automatic wait_req_log();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #2;
            found = (req_log.size() > 0);
        end
        if (!found) chk("timeout_req", 32'd0, 32'd1);
    endtask

    task automatic wait_xfers(input int n);
        bit found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk); #2;
            found = (xpc_log.size() >= n);
        end
        if (!found) chk("timeout_xfer", 32'd0, 32'd1);
    endtask

    logic [7:0] held, orig;

    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            mem[a] = {4'h1, av[3:0], ~av};
        end
        reset = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", 32'(instr_out), 32'h0000);
        chk("rst_pc_out", 32'(pc_out), 32'h00);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr_fe", 32'(addr2), 32'hFE);

        // Back-to-back fetches, ack in the first REQ cycle.
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        repeat (8) @(negedge clk);
        #2;
        chk("req_idle_after_rel", 32'(reqtr_log[0]), 32'd0);
        chk("req_first_rise", 32'(reqtr_log[1]), 32'd1);
        chk("valid_seq", {28'd0, vld_log[1], vld_log[2], vld_log[3], vld_log[4]}, 32'b0101);
        chk("valid_seq2", {30'd0, vld_log[5], vld_log[6]}, 32'b01);
        chk("req_addr0", 32'(req_log[0]), 32'h00);
        chk("req_addr1", 32'(req_log[1]), 32'h01);
        chk("req_addr2", 32'(req_log[2]), 32'h02);
        chk("xfer_pc0", 32'(xpc_log[0]), 32'h00);
        chk("xfer_pc2", 32'(xpc_log[2]), 32'h02);
        chk("xfer_in0", 32'(xin_log[0]), 32'h10FF);
        chk("xfer_in1", 32'(xin_log[1]), 32'h11FE);
        chk("xfer_in2", 32'(xin_log[2]), 32'h12FD);
        chk("wrap_addr0", 32'(req2_log[0]), 32'hFE);
        chk("wrap_addr1", 32'(req2_log[1]), 32'hFF);
        chk("wrap_addr2", 32'(req2_log[2]), 32'h00);

        // Backpressure: hold for 5 cycles.
        @(negedge clk);
        id_ready = 1'b0;
        wait_valid();
        held = pc_out;
        req_log.delete();
        repeat (5) @(negedge clk);
        #2;
        chk("bp_valid", 32'(if_valid), 32'd1);
        chk("bp_pc_stable", 32'(pc_out), 32'(held));
        chk("bp_no_req", 32'(req_log.size()), 32'd0);
        @(negedge clk);
        id_ready = 1'b1;
        wait_req_log();
        chk("bp_next_addr", 32'(req_log[0]), 32'(held + 8'd1));

        // Redirect during a slow request: outstanding ack is discarded.
        wait_ack();
        @(negedge clk);
        ack_delay = 3;
        repeat (2) @(negedge clk);
        orig = imem_addr;
        redirect_valid = 1'b1; redirect_addr = 8'h40;
        clear_logs();
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("squash_req_held", 32'(imem_req), 32'd1);
        chk("squash_addr_held", 32'(imem_addr), 32'(orig));
        wait_xfers(1);
        chk("squash_next_req", 32'(req_log[0]), 32'h40);
        chk("squash_first_xfer", 32'(xpc_log[0]), 32'h40);

        // Redirect while holding with id_ready=1: instruction dropped.
        @(negedge clk);
        ack_delay = 0;
        wait_ack();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_addr = 8'h10;
        clear_logs();
        #2;
        chk("drop_in_hold", 32'(if_valid), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("drop_valid_fall", 32'(if_valid), 32'd0);
        wait_xfers(1);
        chk("drop_next_req", 32'(req_log[0]), 32'h10);
        chk("drop_first_xfer", 32'(xpc_log[0]), 32'h10);

        // Halt opcode at 05.
        mem[5] = 16'hF000;
        wait_ack();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_addr = 8'h04;
        @(negedge clk);
        redirect_valid = 1'b0;
        clear_logs();
        wait_xfers(2);
        chk("halt_xfer_pc", 32'(xpc_log[1]), 32'h05);
        chk("halt_xfer_in", 32'(xin_log[1]), 32'hF000);
        req_log.delete();
        repeat (5) @(negedge clk);
        #2;
`ifdef IF_HALT_EN
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(req_log.size()), 32'd0);
        chk("halt_pc_after", 32'(imem_addr), 32'h06);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_addr = 8'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        chk("halt_exit_clr", 32'(halted), 32'd0);
        chk("halt_exit_req", 32'(imem_req), 32'd1);
        chk("halt_exit_addr", 32'(imem_addr), 32'h20);
`else
        chk("nohalt_flag", 32'(halted), 32'd0);
        chk("nohalt_next_req", 32'(req_log[0]), 32'h06);
`endif

        // Asynchronous reset in the middle of a hold.
        wait_ack();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc_out", 32'(pc_out), 32'h00);
        chk("arst_addr", 32'(imem_addr), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        wait_xfers(1);
        chk("arst_first_req", 32'(req_log[0]), 32'h00);
        chk("arst_first_xfer", 32'(xpc_log[0]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
